// File: rtl/b06_cont_cmp.sv
// Event counter and target comparator that feeds CONT_EQL to the b06 interrupt FSM.
// It counts enabled cycles up to a selectable target and holds the match until the FSM acknowledges it.
module b06_cont_cmp #(
  parameter int unsigned CW    = 8,
  parameter int unsigned TGT_1 = 10,
  parameter int unsigned TGT_2 = 20,
  parameter int unsigned TGT_3 = 40
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          ENABLE_COUNT,
  input  logic [1:0]    CC_MUX,
  input  logic          ACKOUT,
  output logic          CONT_EQL,
  output logic [CW-1:0] COUNT,
  output logic          OVF,
  output logic          BUSY
);

  localparam logic [CW-1:0] L_TGT_1 = CW'(TGT_1);
  localparam logic [CW-1:0] L_TGT_2 = CW'(TGT_2);
  localparam logic [CW-1:0] L_TGT_3 = CW'(TGT_3);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_MATCH    = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_eql;
  logic          r_ovf;
  logic          r_busy;

  logic [CW-1:0] w_tgt;
  logic          w_sel_ok;
  logic          w_cnt_max;
  logic [CW-1:0] w_cnt_inc;
  logic          w_inc_hit;

  // Target is re-selected every cycle; 2'b00 means "no target" and pauses counting.
  always_comb begin
    w_tgt = '0;
    case (CC_MUX)
      2'b01:   w_tgt = L_TGT_1;
      2'b10:   w_tgt = L_TGT_2;
      2'b11:   w_tgt = L_TGT_3;
      default: w_tgt = '0;
    endcase
  end

  assign w_sel_ok  = (CC_MUX != 2'b00);
  assign w_cnt_max = (r_count == {CW{1'b1}});
  assign w_cnt_inc = r_count + CW'(1);
  assign w_inc_hit = (w_cnt_inc == w_tgt);

  // Single-process FSM; all outputs are registered with the state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_eql   <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          r_eql   <= 1'b0;
          if (ENABLE_COUNT) begin
            r_busy <= 1'b1;
            if (w_sel_ok && (w_tgt == '0)) begin
              r_state <= ST_MATCH;
              r_eql   <= 1'b1;
            end else begin
              r_state <= ST_COUNT;
            end
          end
        end

        ST_COUNT: begin
          // Disabled or unselected cycles are a pause, never an abort.
          if (ENABLE_COUNT && w_sel_ok) begin
            if (!w_cnt_max) begin
              r_count <= w_cnt_inc;
              if (w_inc_hit) begin
                r_eql   <= 1'b1;
                r_state <= ST_MATCH;
              end
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end

        ST_MATCH: begin
          if (ACKOUT) begin
            r_count <= '0;
            r_eql   <= 1'b0;
            r_ovf   <= 1'b0;
            if (ENABLE_COUNT) begin
              r_state <= ST_WAIT_REL;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        ST_WAIT_REL: begin
          // A fresh enable edge is required before the next run.
          r_count <= '0;
          r_eql   <= 1'b0;
          if (!ENABLE_COUNT) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
          r_eql   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign CONT_EQL = r_eql;
  assign COUNT    = r_count;
  assign OVF      = r_ovf;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_b06_cont_cmp.sv
// Directed bench for b06_cont_cmp: a vector table for the main counting flows plus
// hand-written sequences for saturation at a narrow width, zero target and async reset.
module tb_b06_cont_cmp;

  logic       CLOCK;
  logic       RESET_N;
  logic       ENABLE_COUNT;
  logic [1:0] CC_MUX;
  logic       ACKOUT;

  logic       a_eql, a_ovf, a_busy;
  logic [7:0] a_count;
  logic       s_eql, s_ovf, s_busy;
  logic [3:0] s_count;
  logic       z_eql, z_ovf, z_busy;
  logic [7:0] z_count;

  int n_tests = 0;
  int n_fail  = 0;

  b06_cont_cmp u_a (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE_COUNT(ENABLE_COUNT), .CC_MUX(CC_MUX),
    .ACKOUT(ACKOUT), .CONT_EQL(a_eql), .COUNT(a_count), .OVF(a_ovf), .BUSY(a_busy)
  );

  b06_cont_cmp #(.CW(4), .TGT_1(10), .TGT_2(20), .TGT_3(15)) u_s (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE_COUNT(ENABLE_COUNT), .CC_MUX(CC_MUX),
    .ACKOUT(ACKOUT), .CONT_EQL(s_eql), .COUNT(s_count), .OVF(s_ovf), .BUSY(s_busy)
  );

  b06_cont_cmp #(.CW(8), .TGT_1(0), .TGT_2(7), .TGT_3(40)) u_z (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE_COUNT(ENABLE_COUNT), .CC_MUX(CC_MUX),
    .ACKOUT(ACKOUT), .CONT_EQL(z_eql), .COUNT(z_count), .OVF(z_ovf), .BUSY(z_busy)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       en;
    logic [1:0] mux;
    logic       ack;
    int         n;
    logic       eql;
    int         cnt;
    logic       ovf;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic [1:0] mux, input logic ack,
                              input int n, input logic eql, input int cnt,
                              input logic ovf, input logic busy);
    vec_t v;
    v.en = en; v.mux = mux; v.ack = ack; v.n = n;
    v.eql = eql; v.cnt = cnt; v.ovf = ovf; v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic do_reset();
    ENABLE_COUNT = 1'b0;
    CC_MUX       = 2'b00;
    ACKOUT       = 1'b0;
    RESET_N      = 1'b0;
    step(2);
    RESET_N = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset.eql",   32'(a_eql),   0);
    chk("reset.count", 32'(a_count), 0);
    chk("reset.ovf",   32'(a_ovf),   0);
    chk("reset.busy",  32'(a_busy),  0);

    // Basic match on target 10, ack with enable high, then release.
    add(1, 2'b01, 0, 1,  0, 0,  0, 1);
    add(1, 2'b01, 0, 9,  0, 9,  0, 1);
    add(1, 2'b01, 0, 1,  1, 10, 0, 1);
    add(1, 2'b01, 0, 3,  1, 10, 0, 1);
    add(1, 2'b01, 1, 1,  0, 0,  0, 1);
    add(1, 2'b01, 0, 2,  0, 0,  0, 1);
    add(0, 2'b01, 0, 1,  0, 0,  0, 0);
    // Pause of 3 cycles at COUNT=5 on target 20.
    add(1, 2'b10, 0, 6,  0, 5,  0, 1);
    add(0, 2'b10, 0, 3,  0, 5,  0, 1);
    add(1, 2'b10, 0, 14, 0, 19, 0, 1);
    add(1, 2'b10, 0, 1,  1, 20, 0, 1);
    add(0, 2'b10, 1, 1,  0, 0,  0, 0);
    // Hold select 00 from IDLE and mid-run, then resume on target 10.
    add(1, 2'b00, 0, 3,  0, 0,  0, 1);
    add(1, 2'b01, 0, 3,  0, 3,  0, 1);
    add(1, 2'b00, 0, 4,  0, 3,  0, 1);
    add(1, 2'b01, 0, 6,  0, 9,  0, 1);
    add(1, 2'b01, 0, 1,  1, 10, 0, 1);
    add(0, 2'b01, 1, 1,  0, 0,  0, 0);
    // Switch 11->01 at COUNT=15: target now behind, count runs on and saturates.
    add(1, 2'b11, 0, 16, 0, 15, 0, 1);
    add(1, 2'b01, 0, 20, 0, 35, 0, 1);
    add(1, 2'b01, 0, 230, 0, 255, 1, 1);

    foreach (vecs[k]) begin
      ENABLE_COUNT = vecs[k].en;
      CC_MUX       = vecs[k].mux;
      ACKOUT       = vecs[k].ack;
      step(vecs[k].n);
      chk($sformatf("v%0d.eql", k),   32'(a_eql),   32'(vecs[k].eql));
      chk($sformatf("v%0d.count", k), 32'(a_count), vecs[k].cnt);
      chk($sformatf("v%0d.ovf", k),   32'(a_ovf),   32'(vecs[k].ovf));
      chk($sformatf("v%0d.busy", k),  32'(a_busy),  32'(vecs[k].busy));
    end

    // CW=4, TGT_3=15: leave target 15 at COUNT=12, saturate at 15 with sticky OVF.
    do_reset();
    ENABLE_COUNT = 1'b1;
    CC_MUX       = 2'b11;
    step(13);
    chk("sat.count12", 32'(s_count), 12);
    CC_MUX = 2'b01;
    step(3);
    chk("sat.count15", 32'(s_count), 15);
    chk("sat.ovf_pre", 32'(s_ovf),   0);
    step(2);
    chk("sat.count_hold", 32'(s_count), 15);
    chk("sat.ovf",        32'(s_ovf),   1);
    chk("sat.eql",        32'(s_eql),   0);
    ENABLE_COUNT = 1'b0;
    step(2);
    chk("sat.ovf_sticky", 32'(s_ovf),  1);
    chk("sat.busy",       32'(s_busy), 1);

    // Zero target: match on the first edge, ack with enable low goes straight to IDLE.
    do_reset();
    ENABLE_COUNT = 1'b1;
    CC_MUX       = 2'b01;
    step(1);
    chk("zero.eql",   32'(z_eql),   1);
    chk("zero.count", 32'(z_count), 0);
    chk("zero.busy",  32'(z_busy),  1);
    ENABLE_COUNT = 1'b0;
    ACKOUT       = 1'b1;
    step(1);
    chk("zero.ack_eql",  32'(z_eql),  0);
    chk("zero.ack_busy", 32'(z_busy), 0);
    ACKOUT = 1'b0;

    // Async reset in MATCH with COUNT=7 clears outputs between clock edges.
    do_reset();
    ENABLE_COUNT = 1'b1;
    CC_MUX       = 2'b10;
    step(8);
    chk("arst.pre_eql",   32'(z_eql),   1);
    chk("arst.pre_count", 32'(z_count), 7);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst.eql",   32'(z_eql),   0);
    chk("arst.count", 32'(z_count), 0);
    chk("arst.ovf",   32'(z_ovf),   0);
    chk("arst.busy",  32'(z_busy),  0);
    ENABLE_COUNT = 1'b0;
    step(1);
    RESET_N = 1'b1;
    step(1);
    chk("arst.idle_busy",  32'(z_busy),  0);
    chk("arst.idle_count", 32'(z_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/b06_cont_cmp.md
Name: b06_cont_cmp

Overview:
Programmable event counter and comparator that sits directly upstream of the b06 interrupt-handler FSM. It counts cycles while the FSM asserts ENABLE_COUNT and compares the count against a target chosen by CC_MUX. It raises CONT_EQL on a match and holds it until the FSM acknowledges with ACKOUT. It closes the counter loop that the FSM's CONT_EQL input expects.

Parameters:
CW, 8, counter width in bits (2..16)
TGT_1, 8'd10, target selected when CC_MUX=2'b01
TGT_2, 8'd20, target selected when CC_MUX=2'b10
TGT_3, 8'd40, target selected when CC_MUX=2'b11

Ports:
CLOCK  in  1  single system clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
ENABLE_COUNT  in  1  count enable from FSM
CC_MUX  in  2  target select from FSM; 2'b00 = no target (hold)
ACKOUT  in  1  match acknowledge from FSM
CONT_EQL  out  1  registered match flag to FSM
COUNT  out  CW  current count value
OVF  out  1  sticky saturation flag
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock domain (CLOCK). RESET_N is asynchronous and active-low. While RESET_N=0: state=IDLE, COUNT=0, CONT_EQL=0, OVF=0, BUSY=0. Release is synchronous to the next CLOCK edge. Reset asserted mid-operation aborts immediately; there is no partial state.
- All outputs are registered. There is no combinational path from input to output.
- tgt = TGT_1 / TGT_2 / TGT_3 for CC_MUX = 01 / 10 / 11. Targets are truncated to CW bits.
- sel_ok = (CC_MUX != 00). tgt is re-evaluated every cycle from the current CC_MUX.
- IDLE:
  - COUNT held at 0.
  - ENABLE_COUNT=1 and sel_ok and tgt==0 -> MATCH with CONT_EQL<=1.
  - ENABLE_COUNT=1 otherwise -> COUNT.
- COUNT:
  - Increment condition: ENABLE_COUNT=1, sel_ok, COUNT != all-ones. Then COUNT<=COUNT+1.
  - If (COUNT+1)==tgt at that increment: CONT_EQL<=1, go to MATCH.
  - ENABLE_COUNT=0 or CC_MUX=00: hold COUNT and stay in COUNT (pause, not abort).
  - COUNT==all-ones with ENABLE_COUNT=1 and no match: COUNT holds (saturates), OVF<=1. Stay in COUNT.
  - A CC_MUX change to a target below the current COUNT gives no match until a reset or a new run.
  - ACKOUT is ignored in COUNT.
- MATCH:
  - CONT_EQL=1 and COUNT frozen, regardless of ENABLE_COUNT or CC_MUX.
  - ACKOUT=1 clears COUNT<=0, CONT_EQL<=0 and OVF<=0.
  - Next state after ACKOUT=1 is WAIT_REL if ENABLE_COUNT=1, else IDLE. The same-cycle ACKOUT=1 with ENABLE_COUNT=0 case goes straight to IDLE.
- WAIT_REL:
  - COUNT=0, CONT_EQL=0.
  - Waits for ENABLE_COUNT=0, then goes to IDLE. This guarantees each run starts on a fresh enable edge.
- OVF is cleared only by reset or by a MATCH acknowledge.
- Latency: with ENABLE_COUNT held high from cycle 0 in IDLE and target T>0, CONT_EQL rises T+1 rising edges after ENABLE_COUNT is first sampled high. A paused cycle adds one cycle each.
- BUSY = (state != IDLE), registered alongside the state.

Test Plan:
- Reset: RESET_N=0 asynchronously mid-MATCH with COUNT=7 -> CONT_EQL, COUNT, OVF and BUSY go to 0 without a clock edge; after release, IDLE.
- Basic match: CC_MUX=01, ENABLE_COUNT held 1 from IDLE -> CONT_EQL=1 on edge 11, COUNT=10. It stays 1 until ACKOUT. ACKOUT=1 for one cycle with ENABLE_COUNT=1 -> COUNT=0, CONT_EQL=0, WAIT_REL. Dropping ENABLE_COUNT -> IDLE.
- Pause: CC_MUX=10, ENABLE_COUNT low for 3 cycles at COUNT=5 -> COUNT holds 5. CONT_EQL rises 3 cycles later than the unpaused case, with COUNT=20.
- Select change: at COUNT=15 switch CC_MUX 11->01 -> no match. With CW=4 and TGT_3=15 reached only after the switch, COUNT saturates at 15 and OVF=1 stays high.
- Hold select: CC_MUX=00 with ENABLE_COUNT=1 -> COUNT does not advance, CONT_EQL=0. A later switch to 01 resumes counting from the held value.
- Zero target: TGT_1=0, CC_MUX=01, ENABLE_COUNT=1 in IDLE -> MATCH on the next edge with COUNT=0. ACKOUT=1 with ENABLE_COUNT=0 in the same cycle -> IDLE directly.
